state_snapshot_reader: RTL and testbench



---
 rtl/state_snapshot_reader.sv | 104 ++++++++++
 tb/tb_state_snapshot_reader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/state_snapshot_reader.sv
// Purpose: capture WORDS live state words on request and stream them plus an additive checksum.
// Latency: word 0 is valid the cycle after the capturing edge; one word per handshake, WORDS+1 words total.
// Backpressure: valid/ready; outputs hold while out_ready is low; requests during a busy snapshot are dropped and counted.
module state_snapshot_reader #(
    parameter int WIDTH = 32,
    parameter int WORDS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snap_req,
    input  logic [WORDS*WIDTH-1:0] in_data,
    output logic                   snap_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [3:0]             out_index,
    output logic                   out_last,
    output logic [7:0]             drop_count
);

    localparam int          IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0]  LAST_IDX = 4'(WORDS);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state;
    logic [WIDTH-1:0] buffer [WORDS];
    logic [WIDTH-1:0] checksum;
    logic [WIDTH-1:0] in_sum;
    logic [3:0]       next_idx;
    logic [WIDTH-1:0] next_word;
    logic             handshake;
    logic             final_hs;
    logic             accept;
    logic             reject;

    // Sum of the live words, wrapping modulo 2^WIDTH, loaded into checksum on capture.
    always_comb begin
        in_sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            in_sum = in_sum + in_data[i*WIDTH +: WIDTH];
        end
    end

    // Handshake decode, request acceptance and the word to present after the next advance.
    always_comb begin
        handshake = out_valid && out_ready;
        final_hs  = handshake && (out_index == LAST_IDX);
        accept    = snap_req && ((state == IDLE) || final_hs);
        reject    = snap_req && !accept;
        next_idx  = out_index + 4'd1;
        next_word = (next_idx == LAST_IDX) ? checksum : buffer[next_idx[IW-1:0]];
    end

    // Snapshot storage: written only at an accepted request, frozen for the whole stream.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            for (int i = 0; i < WORDS; i++) begin
                buffer[i] <= in_data[i*WIDTH +: WIDTH];
            end
            checksum <= in_sum;
        end
    end

    // Control FSM with registered stream outputs and the saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            snap_busy  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (reject && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (accept) begin
                // Fresh capture, also covers the back-to-back case on the final handshake.
                state     <= SEND;
                snap_busy <= 1'b1;
                out_valid <= 1'b1;
                out_index <= '0;
                out_last  <= 1'b0;
                out_data  <= in_data[WIDTH-1:0];
            end else if (handshake) begin
                if (final_hs) begin
                    state     <= IDLE;
                    snap_busy <= 1'b0;
                    out_valid <= 1'b0;
                    out_index <= '0;
                    out_last  <= 1'b0;
                    out_data  <= '0;
                end else begin
                    out_index <= next_idx;
                    out_data  <= next_word;
                    out_last  <= (next_idx == LAST_IDX);
                end
            end
        end
    end

endmodule

// File: tb/tb_state_snapshot_reader.sv
// Purpose: randomized self-checking bench for state_snapshot_reader against a queue-based stream model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: out_ready is driven with fixed patterns and random values.
module tb_state_snapshot_reader;

    localparam int WIDTH = 32;
    localparam int WORDS = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   snap_req;
    logic [WORDS*WIDTH-1:0] in_data;
    logic                   snap_busy;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [3:0]             out_index;
    logic                   out_last;
    logic [7:0]             drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the words still owed downstream, in order, with their indices.
    logic [31:0] exp_dat[$];
    int          exp_idx[$];
    int          exp_drops = 0;

    state_snapshot_reader #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .snap_req   (snap_req),
        .in_data    (in_data),
        .snap_busy  (snap_busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WORDS*WIDTH-1:0] rnd_data();
        logic [WORDS*WIDTH-1:0] d;
        for (int k = 0; k < WORDS; k++) d[k*WIDTH +: WIDTH] = $urandom;
        return d;
    endfunction

    // Drive one cycle of inputs, advance the model, clock once and compare everything.
    task automatic step(input bit req, input bit rdy, input bit r, input logic [WORDS*WIDTH-1:0] d);
        logic [31:0] sum;
        logic [31:0] tmp_d;
        int          tmp_i;
        snap_req  = req;
        out_ready = rdy;
        rst       = r;
        in_data   = d;
        if (r) begin
            exp_dat.delete();
            exp_idx.delete();
            exp_drops = 0;
        end else begin
            if (exp_dat.size() > 0 && rdy) begin
                tmp_d = exp_dat.pop_front();
                tmp_i = exp_idx.pop_front();
            end
            if (req) begin
                if (exp_dat.size() == 0) begin
                    sum = 32'd0;
                    for (int k = 0; k < WORDS; k++) begin
                        exp_dat.push_back(d[k*WIDTH +: WIDTH]);
                        exp_idx.push_back(k);
                        sum = sum + d[k*WIDTH +: WIDTH];
                    end
                    exp_dat.push_back(sum);
                    exp_idx.push_back(WORDS);
                end else if (exp_drops < 255) begin
                    exp_drops++;
                end
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_dat.size() > 0));
        check("snap_busy", 32'(snap_busy), 32'(exp_dat.size() > 0));
        check("drop_count", 32'(drop_count), 32'(exp_drops));
        if (exp_dat.size() > 0) begin
            check("out_data", out_data, exp_dat[0]);
            check("out_index", 32'(out_index), 32'(exp_idx[0]));
            check("out_last", 32'(out_last), 32'(exp_idx[0] == WORDS));
        end
        if (r) begin
            check("rst_out_data", out_data, 32'd0);
            check("rst_out_index", 32'(out_index), 32'd0);
            check("rst_out_last", 32'(out_last), 32'd0);
        end
    endtask

    initial begin
        logic [WORDS*WIDTH-1:0] d;
        bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state.
        repeat (3) step(1'b0, 1'b0, 1'b1, '0);

        // Basic capture: words 0..7, checksum 28.
        for (int k = 0; k < WORDS; k++) d[k*WIDTH +: WIDTH] = 32'(k);
        step(1'b1, 1'b1, 1'b0, d);
        repeat (11) step(1'b0, 1'b1, 1'b0, rnd_data());

        // Checksum wrap: all ones gives 0xFFFFFFF8.
        d = '1;
        step(1'b1, 1'b1, 1'b0, d);
        repeat (8) step(1'b0, 1'b1, 1'b0, d);
        check("wrap_checksum", out_data, 32'hFFFF_FFF8);
        step(1'b0, 1'b1, 1'b0, d);

        // Backpressure with live data changing under the frozen snapshot.
        step(1'b1, 1'b0, 1'b0, rnd_data());
        for (int c = 0; c < 30; c++) step(1'b0, pat[c % 5], 1'b0, rnd_data());

        // Continuous requests: back-to-back snapshots and drop saturation.
        for (int c = 0; c < 400; c++) step(1'b1, 1'b1, 1'b0, rnd_data());
        check("drop_saturated", 32'(drop_count), 32'd255);
        for (int c = 0; c < 20; c++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, rnd_data());
        repeat (40) step(1'b0, 1'b1, 1'b0, rnd_data());

        // Reset mid-burst at index 3 with a simultaneous request.
        step(1'b1, 1'b1, 1'b0, rnd_data());
        repeat (3) step(1'b0, 1'b1, 1'b0, rnd_data());
        check("pre_reset_index", 32'(out_index), 32'd3);
        step(1'b1, 1'b1, 1'b1, rnd_data());
        step(1'b0, 1'b1, 1'b0, rnd_data());
        step(1'b1, 1'b1, 1'b0, rnd_data());
        check("restart_index", 32'(out_index), 32'd0);
        repeat (10) step(1'b0, 1'b1, 1'b0, rnd_data());

        // Idle quiet.
        for (int c = 0; c < 100; c++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, rnd_data());

        // Random mix of requests, backpressure and rare resets.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 199) == 0), rnd_data());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
